// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK poll controller.
//   state_e       : transaction scheduler states
//   dir_e         : step direction encoding
//   jstk_sample_t : X/Y/button fields unpacked from the 40-bit DOUT word
package jstk_pkg;

  localparam int unsigned AXIS_W = 10;
  localparam int unsigned BTN_W  = 3;
  localparam int unsigned DOUT_W = 40;
  localparam int unsigned CMD_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  // DIN byte is this prefix followed by the two LED bits
  localparam logic [5:0] LED_PREFIX = 6'b100000;

  // DOUT field positions: X = {dout[25:24], dout[39:32]}, Y = {dout[9:8], dout[23:16]}
  localparam int unsigned X_LO_LSB = 32;
  localparam int unsigned X_HI_LSB = 24;
  localparam int unsigned Y_LO_LSB = 16;
  localparam int unsigned Y_HI_LSB = 8;
  localparam int unsigned BTN_LSB  = 0;

  localparam logic [AXIS_W-1:0] CENTER_DEF = 10'd512;

  typedef struct packed {
    logic [AXIS_W-1:0] x;
    logic [AXIS_W-1:0] y;
    logic [BTN_W-1:0]  btn;
  } jstk_sample_t;

  // Reassemble the split axis fields of a DOUT word
  function automatic jstk_sample_t unpack_dout(input logic [DOUT_W-1:0] dout);
    jstk_sample_t s;
    s.x   = {dout[X_HI_LSB +: 2], dout[X_LO_LSB +: 8]};
    s.y   = {dout[Y_HI_LSB +: 2], dout[Y_LO_LSB +: 8]};
    s.btn = dout[BTN_LSB +: BTN_W];
    return s;
  endfunction

endpackage

// File: rtl/jstk_poll_ctrl_if.sv
// Bus bundle between the poll controller, the PmodJSTK driver and the counter.
//   master : controller side (drives snd_rec/snd_data, positions, buttons, pulses)
//   slave  : environment side (drives enable, led_cmd, jstk_dout)
interface jstk_poll_ctrl_if;
  import jstk_pkg::*;

  logic               enable;
  logic [1:0]         led_cmd;
  logic [DOUT_W-1:0]  jstk_dout;
  logic               snd_rec;
  logic [CMD_W-1:0]   snd_data;
  logic [AXIS_W-1:0]  pos_x;
  logic [AXIS_W-1:0]  pos_y;
  logic [BTN_W-1:0]   buttons;
  logic               sample_valid;
  logic               step_up;
  logic               step_down;
  logic               step_left;
  logic               step_right;

  modport master (
    input  enable, led_cmd, jstk_dout,
    output snd_rec, snd_data, pos_x, pos_y, buttons, sample_valid,
           step_up, step_down, step_left, step_right
  );

  modport slave (
    output enable, led_cmd, jstk_dout,
    input  snd_rec, snd_data, pos_x, pos_y, buttons, sample_valid,
           step_up, step_down, step_left, step_right
  );

endinterface

// File: rtl/jstk_step_decode.sv
// Joystick deflection to step-pulse decoder with auto-repeat.
// Ports:
//   clk, rst        : clock, async active-low reset
//   i_strobe        : capture strobe, i_x/i_y are evaluated only when high
//   i_x, i_y        : raw axis values
//   o_step_*        : registered one-cycle step pulses (at most one at a time)
module jstk_step_decode
  import jstk_pkg::*;
#(
  parameter int unsigned CENTER         = 32'(CENTER_DEF),
  parameter int unsigned DEADZONE       = 64,
  parameter int unsigned REPEAT_SAMPLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_strobe,
  input  logic [AXIS_W-1:0] i_x,
  input  logic [AXIS_W-1:0] i_y,
  output logic              o_step_up,
  output logic              o_step_down,
  output logic              o_step_left,
  output logic              o_step_right
);

  localparam int unsigned DW = AXIS_W + 1;
  localparam int unsigned RW = (REPEAT_SAMPLES > 1) ? $clog2(REPEAT_SAMPLES) : 1;

  logic signed [DW-1:0] w_dx, w_dy;
  logic [DW-1:0]        w_ax, w_ay;
  logic                 w_x_act, w_y_act;
  dir_e                 w_dir;
  dir_e                 r_held, w_held_nxt;
  logic [RW-1:0]        r_rep_cnt, w_rep_nxt;
  logic                 w_fire;

  // Signed deflection from rest and its magnitude
  assign w_dx    = $signed({1'b0, i_x}) - $signed(DW'(CENTER));
  assign w_dy    = $signed({1'b0, i_y}) - $signed(DW'(CENTER));
  assign w_ax    = w_dx[DW-1] ? DW'(-w_dx) : DW'(w_dx);
  assign w_ay    = w_dy[DW-1] ? DW'(-w_dy) : DW'(w_dy);
  assign w_x_act = (w_ax > DW'(DEADZONE));
  assign w_y_act = (w_ay > DW'(DEADZONE));

  // Dominant axis wins; X takes ties
  always_comb begin
    w_dir = DIR_NONE;
    if (w_x_act && (!w_y_act || (w_ax >= w_ay))) begin
      w_dir = w_dx[DW-1] ? DIR_LEFT : DIR_RIGHT;
    end else if (w_y_act) begin
      w_dir = w_dy[DW-1] ? DIR_DOWN : DIR_UP;
    end
  end

  // Auto-repeat: a new direction fires at once, a held one every REPEAT_SAMPLES captures
  always_comb begin
    w_held_nxt = r_held;
    w_rep_nxt  = r_rep_cnt;
    w_fire     = 1'b0;
    if (i_strobe) begin
      if (w_dir == DIR_NONE) begin
        w_held_nxt = DIR_NONE;
        w_rep_nxt  = '0;
      end else if (w_dir != r_held) begin
        w_fire     = 1'b1;
        w_held_nxt = w_dir;
        w_rep_nxt  = '0;
      end else if (r_rep_cnt == RW'(REPEAT_SAMPLES - 1)) begin
        w_fire    = 1'b1;
        w_rep_nxt = '0;
      end else begin
        w_rep_nxt = r_rep_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held       <= DIR_NONE;
      r_rep_cnt    <= '0;
      o_step_up    <= 1'b0;
      o_step_down  <= 1'b0;
      o_step_left  <= 1'b0;
      o_step_right <= 1'b0;
    end else begin
      r_held       <= w_held_nxt;
      r_rep_cnt    <= w_rep_nxt;
      o_step_up    <= w_fire && (w_dir == DIR_UP);
      o_step_down  <= w_fire && (w_dir == DIR_DOWN);
      o_step_left  <= w_fire && (w_dir == DIR_LEFT);
      o_step_right <= w_fire && (w_dir == DIR_RIGHT);
    end
  end

endmodule

// File: rtl/jstk_poll_ctrl.sv
// PmodJSTK transaction scheduler: request / wait / capture on a fixed poll period,
// latches X/Y/buttons and emits joystick step pulses.
// Ports:
//   clk, rst : clock, async active-low reset
//   bus      : jstk_poll_ctrl_if.master (enable, led_cmd, jstk_dout in;
//              snd_rec, snd_data, pos_x, pos_y, buttons, sample_valid, step_* out)
// Optional: define JSTK_BTN_FILTER_EN to update buttons only when two consecutive
// captures agree; otherwise buttons follows every capture.
module jstk_poll_ctrl
  import jstk_pkg::*;
#(
  parameter int unsigned POLL_DIV       = 20_000_000,
  parameter int unsigned REQ_HOLD       = 1_000,
  parameter int unsigned XFER_WAIT      = 200_000,
  parameter int unsigned CENTER         = 32'(CENTER_DEF),
  parameter int unsigned DEADZONE       = 64,
  parameter int unsigned REPEAT_SAMPLES = 3
) (
  input logic            clk,
  input logic            rst,
  jstk_poll_ctrl_if.master bus
);

  localparam int unsigned PW     = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned PH_MAX = (REQ_HOLD > XFER_WAIT) ? REQ_HOLD : XFER_WAIT;
  localparam int unsigned CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_e             r_state, w_state_nxt;
  logic [PW-1:0]      r_poll_cnt;
  logic               w_poll_tick;
  logic [CW-1:0]      r_phase_cnt, w_phase_nxt;
  logic               r_snd_rec, w_snd_rec_nxt;
  logic [CMD_W-1:0]   r_snd_data, w_snd_data_nxt;
  logic               w_capture;
  jstk_sample_t       w_sample;
  logic [AXIS_W-1:0]  r_pos_x, r_pos_y;
  logic [BTN_W-1:0]   r_buttons, w_btn_nxt;
  logic               r_sample_valid;

  assign w_sample = unpack_dout(bus.jstk_dout);

  // Free-running poll divider keeps the period exact; ticks during a transaction are dropped
  assign w_poll_tick = (r_poll_cnt == PW'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_poll_cnt <= '0;
    end else if (w_poll_tick) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + PW'(1);
    end
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_snd_rec   <= 1'b0;
      r_snd_data  <= {LED_PREFIX, 2'b00};
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_snd_rec   <= w_snd_rec_nxt;
      r_snd_data  <= w_snd_data_nxt;
    end
  end

  // Next-state logic; snd_rec is decoded from the next state so it is registered
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = '0;
    w_snd_rec_nxt  = 1'b0;
    w_snd_data_nxt = r_snd_data;
    w_capture      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_poll_tick && bus.enable) begin
          w_state_nxt    = ST_REQ;
          w_snd_rec_nxt  = 1'b1;
          w_snd_data_nxt = {LED_PREFIX, bus.led_cmd};
        end
      end
      ST_REQ: begin
        if (r_phase_cnt == CW'(REQ_HOLD - 1)) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_phase_nxt   = r_phase_cnt + CW'(1);
          w_snd_rec_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_phase_cnt == CW'(XFER_WAIT - 1)) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_phase_nxt = r_phase_cnt + CW'(1);
        end
      end
      ST_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef JSTK_BTN_FILTER_EN
  // Debounce: accept a button pattern only once it repeats on the next capture
  logic [BTN_W-1:0] r_btn_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_prev <= '0;
    end else if (w_capture) begin
      r_btn_prev <= w_sample.btn;
    end
  end

  assign w_btn_nxt = (w_sample.btn == r_btn_prev) ? w_sample.btn : r_buttons;
`else
  assign w_btn_nxt = w_sample.btn;
`endif

  // Sample latch; sample_valid lines up with the step pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos_x        <= CENTER_DEF;
      r_pos_y        <= CENTER_DEF;
      r_buttons      <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_capture;
      if (w_capture) begin
        r_pos_x   <= w_sample.x;
        r_pos_y   <= w_sample.y;
        r_buttons <= w_btn_nxt;
      end
    end
  end

  jstk_step_decode #(
    .CENTER         (CENTER),
    .DEADZONE       (DEADZONE),
    .REPEAT_SAMPLES (REPEAT_SAMPLES)
  ) u_step_decode (
    .clk          (clk),
    .rst          (rst),
    .i_strobe     (w_capture),
    .i_x          (w_sample.x),
    .i_y          (w_sample.y),
    .o_step_up    (bus.step_up),
    .o_step_down  (bus.step_down),
    .o_step_left  (bus.step_left),
    .o_step_right (bus.step_right)
  );

  assign bus.snd_rec      = r_snd_rec;
  assign bus.snd_data     = r_snd_data;
  assign bus.pos_x        = r_pos_x;
  assign bus.pos_y        = r_pos_y;
  assign bus.buttons      = r_buttons;
  assign bus.sample_valid = r_sample_valid;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Directed bench for jstk_poll_ctrl with a capture scoreboard.
module tb_jstk_poll_ctrl;

  localparam int unsigned POLL_DIV  = 100;
  localparam int unsigned REQ_HOLD  = 4;
  localparam int unsigned XFER_WAIT = 10;

  localparam logic [3:0] S_N = 4'b0000;
  localparam logic [3:0] S_U = 4'b1000;
  localparam logic [3:0] S_D = 4'b0100;
  localparam logic [3:0] S_L = 4'b0010;
  localparam logic [3:0] S_R = 4'b0001;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
    logic [3:0] step;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t q[$];
  logic [2:0] m_prev;
  logic [2:0] m_btn;

  jstk_poll_ctrl_if bus ();

  jstk_poll_ctrl #(
    .POLL_DIV       (POLL_DIV),
    .REQ_HOLD       (REQ_HOLD),
    .XFER_WAIT      (XFER_WAIT),
    .CENTER         (512),
    .DEADZONE       (64),
    .REPEAT_SAMPLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] steps();
    return {bus.step_up, bus.step_down, bus.step_left, bus.step_right};
  endfunction

  task automatic drive_dout(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn);
    bus.jstk_dout = {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
  endtask

  // Reference for the buttons register
  function automatic logic [2:0] model_btn(input logic [2:0] btn);
`ifdef JSTK_BTN_FILTER_EN
    logic [2:0] r;
    r = (btn == m_prev) ? btn : m_btn;
    m_prev = btn;
    m_btn  = r;
    return r;
`else
    return btn;
`endif
  endfunction

  task automatic push_exp(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn,
                          input logic [3:0] step);
    exp_t e;
    e.x    = x;
    e.y    = y;
    e.btn  = model_btn(btn);
    e.step = step;
    q.push_back(e);
  endtask

  task automatic check_sample();
    exp_t e;
    if (q.size() == 0) begin
      chk("sb_pending", 40'(q.size()), 40'(1));
    end else begin
      e = q.pop_front();
      chk("pos_x", 40'(bus.pos_x), 40'(e.x));
      chk("pos_y", 40'(bus.pos_y), 40'(e.y));
      chk("buttons", 40'(bus.buttons), 40'(e.btn));
      chk("steps", 40'(steps()), 40'(e.step));
    end
  endtask

  // Wait (bounded) for the next sample_valid, flagging any step pulse outside it
  task automatic wait_sample();
    int n;
    int stray;
    n = 0;
    stray = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.sample_valid && (steps() != 4'b0000)) stray++;
    end while (!bus.sample_valid && (n < 3 * POLL_DIV));
    chk("stray_step", 40'(stray), 40'(0));
    chk("sample_seen", 40'(bus.sample_valid), 40'(1));
    if (bus.sample_valid) check_sample();
  endtask

  task automatic cap(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn,
                     input logic [3:0] step);
    drive_dout(x, y, btn);
    push_exp(x, y, btn, step);
    wait_sample();
  endtask

  initial begin
    int first;
    int hi_cnt;
    int bad_data;
    int sv_cnt;
    int sv_at;
    int n;
    n_tests = 0;
    n_fail  = 0;
    m_prev  = 3'b000;
    m_btn   = 3'b000;
    rst         = 1'b0;
    bus.enable  = 1'b1;
    bus.led_cmd = 2'b01;
    drive_dout(10'd512, 10'd512, 3'b000);

    // Reset values
    #12;
    chk("rst_snd_rec", 40'(bus.snd_rec), 40'(0));
    chk("rst_snd_data", 40'(bus.snd_data), 40'(8'h80));
    chk("rst_pos_x", 40'(bus.pos_x), 40'(512));
    chk("rst_pos_y", 40'(bus.pos_y), 40'(512));
    chk("rst_buttons", 40'(bus.buttons), 40'(0));
    chk("rst_valid", 40'(bus.sample_valid), 40'(0));
    chk("rst_steps", 40'(steps()), 40'(0));

    // 1: first transaction timing, DIN byte held even if led_cmd moves
    @(negedge clk);
    rst = 1'b1;
    push_exp(10'd512, 10'd512, 3'b000, S_N);
    first = -1; hi_cnt = 0; bad_data = 0; sv_cnt = 0; sv_at = -1;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      if (bus.snd_rec) begin
        if (first < 0) first = i;
        hi_cnt++;
        if (bus.snd_data !== 8'h81) bad_data++;
      end
      if (i == 101) bus.led_cmd = 2'b10;
      if (bus.sample_valid) begin
        sv_cnt++;
        sv_at = i;
        check_sample();
      end
    end
    chk("req_start", 40'(first), 40'(100));
    chk("req_len", 40'(hi_cnt), 40'(REQ_HOLD));
    chk("snd_data_bad", 40'(bad_data), 40'(0));
    chk("valid_count", 40'(sv_cnt), 40'(1));
    chk("valid_cycle", 40'(sv_at), 40'(100 + REQ_HOLD + XFER_WAIT + 1));

    // 2: held right repeats on captures 1 and 4; centering releases the hold
    cap(10'd700, 10'd512, 3'b000, S_R);
    cap(10'd700, 10'd512, 3'b000, S_N);
    cap(10'd700, 10'd512, 3'b000, S_N);
    cap(10'd700, 10'd512, 3'b000, S_R);
    cap(10'd700, 10'd512, 3'b000, S_N);
    cap(10'd512, 10'd512, 3'b000, S_N);
    cap(10'd700, 10'd512, 3'b000, S_R);

    // 3: larger |dy| wins; tie goes to X
    cap(10'd600, 10'd300, 3'b000, S_D);
    cap(10'd700, 10'd324, 3'b000, S_R);

    // 4: deflection equal to the deadzone is not a step
    cap(10'd576, 10'd512, 3'b000, S_N);
    cap(10'd300, 10'd512, 3'b000, S_L);
    cap(10'd512, 10'd700, 3'b000, S_U);

    // 6: button sequence (filtered or raw depending on build)
    cap(10'd540, 10'd480, 3'b001, S_N);
    cap(10'd540, 10'd480, 3'b000, S_N);
    cap(10'd540, 10'd480, 3'b001, S_N);
    cap(10'd540, 10'd480, 3'b001, S_N);

    // 5a: async reset while in WAIT
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.snd_rec && n < 2 * POLL_DIV);
    chk("rise_seen", 40'(bus.snd_rec), 40'(1));
    n = 0;
    do begin @(negedge clk); n++; end while (bus.snd_rec && n < 2 * REQ_HOLD);
    chk("fall_seen", 40'(bus.snd_rec), 40'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_snd_rec", 40'(bus.snd_rec), 40'(0));
    chk("mid_rst_pos_x", 40'(bus.pos_x), 40'(512));
    chk("mid_rst_pos_y", 40'(bus.pos_y), 40'(512));
    chk("mid_rst_buttons", 40'(bus.buttons), 40'(0));
    chk("mid_rst_snd_data", 40'(bus.snd_data), 40'(8'h80));
    m_prev = 3'b000;
    m_btn  = 3'b000;
    @(negedge clk);
    rst = 1'b1;

    // 5b: next request a full period after release; dropping enable in REQ still captures
    drive_dout(10'd520, 10'd512, 3'b000);
    push_exp(10'd520, 10'd512, 3'b000, S_N);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.snd_rec && n < 3 * POLL_DIV);
    chk("post_rst_req", 40'(n), 40'(POLL_DIV));
    bus.enable = 1'b0;
    wait_sample();
    hi_cnt = 0;
    sv_cnt = 0;
    for (int i = 0; i < 3 * POLL_DIV; i++) begin
      @(negedge clk);
      if (bus.snd_rec) hi_cnt++;
      if (bus.sample_valid) sv_cnt++;
    end
    chk("no_req_disabled", 40'(hi_cnt), 40'(0));
    chk("no_valid_disabled", 40'(sv_cnt), 40'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jstk_poll_ctrl.md
Name: jstk_poll_ctrl

Overview:
- Sequences PmodJSTK SPI transactions and replaces the free-running 5 Hz send/receive divider with a counted request/wait/capture scheduler.
- Drives sndRec and DIN, and latches the 40-bit DOUT into registered X/Y/button fields.
- Converts joystick deflection into one-cycle step pulses (up/down/left/right) with auto-repeat, for the stopwatch counter's adjust mode.
- Sits in master_control between PmodJSTK and counter.

Parameters:
- POLL_DIV, 20_000_000: clk cycles between transaction starts (5 Hz at 100 MHz).
- REQ_HOLD, 1_000: cycles snd_rec is held high per transaction.
- XFER_WAIT, 200_000: cycles after snd_rec falls before DOUT is captured.
- CENTER, 512: axis rest value.
- DEADZONE, 64: deflection magnitude (strictly greater than) needed to register a step.
- REPEAT_SAMPLES, 3: captures between repeated steps while the stick is held.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  permits new transactions
- led_cmd  in  2  LED state sent to PmodJSTK
- jstk_dout  in  40  PmodJSTK DOUT
- snd_rec  out  1  transaction request to PmodJSTK
- snd_data  out  8  DIN byte to PmodJSTK
- pos_x  out  10  latched X position
- pos_y  out  10  latched Y position
- buttons  out  3  latched buttons
- sample_valid  out  1  one-cycle pulse per capture
- step_up, step_down, step_left, step_right  out  1 each  one-cycle step pulses

Behaviour:
- Reset (rst=0, asynchronous, any state, including mid-transfer):
  - FSM returns to IDLE.
  - All counters are cleared.
  - snd_rec=0, snd_data=8'h80, pos_x=pos_y=10'd512, buttons=0, all pulses=0, repeat counter=0, held direction=NONE.
- FSM states: IDLE -> REQ -> WAIT -> CAPTURE -> IDLE.
- IDLE:
  - poll_cnt increments every cycle regardless of enable.
  - When poll_cnt==POLL_DIV-1, poll_cnt wraps to 0.
  - On that wrap, if enable=1, go to REQ; otherwise the tick is dropped (no queuing).
- REQ:
  - snd_rec=1 and snd_data={6'b100000, led_cmd}, sampled on entry and held constant for the whole transaction.
  - Leave after REQ_HOLD cycles.
- WAIT: snd_rec=0; leave after XFER_WAIT cycles.
- CAPTURE: one cycle.
  - pos_x <= {dout[25:24],dout[39:32]}, pos_y <= {dout[9:8],dout[23:16]}, buttons <= dout[2:0].
  - sample_valid pulses on the following cycle, together with any step pulse.
- Deassertion of enable:
  - Mid-transaction (REQ/WAIT): the current transaction completes and captures.
  - No new REQ starts while enable=0.
- Step decode:
  - Compute dx=x-CENTER and dy=y-CENTER as 11-bit signed values.
  - Active when |d|>DEADZONE.
  - If both axes are active, the axis with the larger |d| wins; on a tie, X wins.
  - dx>0 gives right, dx<0 left; dy>0 up, dy<0 down.
- Auto-repeat:
  - A new direction (different from the held direction) fires immediately and sets repeat_cnt=0.
  - The same direction increments repeat_cnt per capture; the step fires again when repeat_cnt reaches REPEAT_SAMPLES, and the counter resets to 0.
  - Inactive resets the held direction to NONE.
  - At most one step pulse is asserted in any cycle.
- Poll period is exact: each transaction starts POLL_DIV cycles after the previous poll tick. The transaction length REQ_HOLD+XFER_WAIT+1 must be less than POLL_DIV; ticks arriving mid-transaction are dropped.

Optional Feature:
- Macro: JSTK_BTN_FILTER_EN.
- Defined: buttons updates only when two consecutive captures carry identical dout[2:0]; otherwise the previous value is held. Reset value is still 0.
- Undefined: buttons takes raw dout[2:0] on every capture.

Decomposition:
- Package jstk_pkg holds:
  - FSM state encodings (IDLE/REQ/WAIT/CAPTURE).
  - Direction encoding (NONE/UP/DOWN/LEFT/RIGHT).
  - LED command prefix 6'b100000.
  - DOUT bit-field positions.
  - CENTER default.
- One sub-module: jstk_step_decode (deadzone compare, axis priority, auto-repeat counter), clocked, enabled by the capture strobe.
- The FSM and counters stay in jstk_poll_ctrl.

Test Plan:
Bench parameters: POLL_DIV=100, REQ_HOLD=4, XFER_WAIT=10, DEADZONE=64, REPEAT_SAMPLES=3.
1. Release reset with enable=1 and led_cmd=2'b01 -> snd_rec high for exactly 4 cycles starting at cycle 100, snd_data=8'h81, capture 10 cycles after the fall, sample_valid exactly once.
2. dout with x=10'd700, y=10'd512 held for 5 captures -> step_right on captures 1 and 4 only. Then x=10'd512 -> no pulses, held direction resets.
3. x=10'd600, y=10'd300 (|dx|=88, |dy|=212) -> step_down only. Then x=10'd700, y=10'd324 (tie at 188) -> step_right.
4. x=10'd576 (|dx|=64, not greater than DEADZONE) -> no step; pos_x=576 still latched.
5. Assert rst=0 during WAIT -> snd_rec=0, pos_x=512, buttons=0 within the same cycle. After release the next request comes a full POLL_DIV later. Separately, drop enable during REQ -> that transaction captures and no further REQ occurs.
6. With JSTK_BTN_FILTER_EN defined, dout[2:0] sequence 3'b001, 3'b000, 3'b001, 3'b001 -> buttons 0, 0, 0, then 3'b001. Without the macro, buttons follows the raw sequence.
